// File: rtl/multicycle_control_unit_pkg.sv
// multicycle_control_unit_pkg: opcode, ALU, mux-select and state encodings for the Antares-R2 multicycle control unit
package multicycle_control_unit_pkg;
    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_BNE  = 6'b000101;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_RT     = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    localparam logic [1:0] PCS_ALU    = 2'b00;
    localparam logic [1:0] PCS_ALUOUT = 2'b01;
    localparam logic [1:0] PCS_JUMP   = 2'b10;

    localparam logic [3:0] S_IDLE    = 4'd0;
    localparam logic [3:0] S_FETCH   = 4'd1;
    localparam logic [3:0] S_DECODE  = 4'd2;
    localparam logic [3:0] S_MEMADDR = 4'd3;
    localparam logic [3:0] S_MEMRD   = 4'd4;
    localparam logic [3:0] S_MEMWB   = 4'd5;
    localparam logic [3:0] S_MEMWR   = 4'd6;
    localparam logic [3:0] S_REX     = 4'd7;
    localparam logic [3:0] S_REXWB   = 4'd8;
    localparam logic [3:0] S_IEX     = 4'd9;
    localparam logic [3:0] S_IWB     = 4'd10;
    localparam logic [3:0] S_BRANCH  = 4'd11;
    localparam logic [3:0] S_JUMP    = 4'd12;
    localparam logic [3:0] S_TRAP    = 4'd13;

    function automatic logic [3:0] dispatch(input logic [5:0] op);
        case (op)
            OP_LW, OP_SW:   return S_MEMADDR;
            OP_R:           return S_REX;
            OP_ADDI:        return S_IEX;
            OP_BEQ, OP_BNE: return S_BRANCH;
            OP_J:           return S_JUMP;
            default:        return S_TRAP;
        endcase
    endfunction
endpackage

// File: rtl/multicycle_control_unit_mem_watchdog.sv
// mem_watchdog: counts memory wait cycles and flags the cycle that exhausts the MEM_TIMEOUT budget
module mem_watchdog #(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_start,
    input  logic i_ready,
    output logic o_timeout
);
    localparam int W = $clog2(MEM_TIMEOUT + 1);

    logic [W-1:0] r_cnt;

    // Cleared whenever no access is pending or the access completes, so back-to-back accesses restart at 0
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            r_cnt <= '0;
        else if (!i_start || i_ready)
            r_cnt <= '0;
        else
            r_cnt <= r_cnt + W'(1);
    end

    assign o_timeout = i_start & ~i_ready & (r_cnt == W'(MEM_TIMEOUT - 1));
endmodule

// File: rtl/multicycle_control_unit.sv
// multicycle_control_unit: Moore FSM sequencing the Antares-R2 multicycle datapath with memory watchdog and traps
module multicycle_control_unit
    import multicycle_control_unit_pkg::*;
#(
    parameter int OPCODE_W    = 6,
    parameter int ALUOP_W     = 2,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic [OPCODE_W-1:0] i_op_code,
    input  logic                i_mem_ready,
    output logic                o_pc_write,
    output logic                o_beq,
    output logic                o_bne,
    output logic                o_i_or_d,
    output logic                o_mem_read,
    output logic                o_mem_write,
    output logic                o_ir_write,
    output logic                o_reg_dst,
    output logic                o_mem_to_reg,
    output logic                o_reg_write,
    output logic                o_alu_src_a,
    output logic [1:0]          o_alu_src_b,
    output logic [ALUOP_W-1:0]  o_alu_op,
    output logic [1:0]          o_pc_source,
    output logic                o_trap
);
    logic [3:0] r_state;
    logic [3:0] w_next;
    logic       r_sel;
    logic       w_mem_state;
    logic       w_timeout;
    logic [5:0] w_op;

    assign w_op        = 6'(i_op_code);
    assign w_mem_state = (r_state == S_FETCH) | (r_state == S_MEMRD) | (r_state == S_MEMWR);

    mem_watchdog #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_watchdog (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_start   (w_mem_state),
        .i_ready   (i_mem_ready),
        .o_timeout (w_timeout)
    );

    // r_sel remembers SW (vs LW) and BNE (vs BEQ) so later states ignore op_code
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
            r_sel   <= 1'b0;
        end else begin
            r_state <= w_next;
            if (r_state == S_DECODE)
                r_sel <= (w_op == OP_SW) | (w_op == OP_BNE);
        end
    end

    always_comb begin
        w_next = S_IDLE;
        case (r_state)
            S_IDLE:    w_next = S_FETCH;
            S_FETCH:   w_next = w_timeout ? S_TRAP : i_mem_ready ? S_DECODE : S_FETCH;
            S_DECODE:  w_next = dispatch(w_op);
            S_MEMADDR: w_next = r_sel ? S_MEMWR : S_MEMRD;
            S_MEMRD:   w_next = w_timeout ? S_TRAP : i_mem_ready ? S_MEMWB : S_MEMRD;
            S_MEMWR:   w_next = w_timeout ? S_TRAP : i_mem_ready ? S_FETCH : S_MEMWR;
            S_REX:     w_next = S_REXWB;
            S_IEX:     w_next = S_IWB;
            S_MEMWB, S_REXWB, S_IWB, S_BRANCH, S_JUMP: w_next = S_FETCH;
            S_TRAP:    w_next = S_TRAP;
            default:   w_next = S_IDLE;
        endcase
    end

    // Outputs decode from the registered state, so asynchronous reset zeroes them immediately
    always_comb begin
        o_pc_write   = 1'b0;
        o_beq        = 1'b0;
        o_bne        = 1'b0;
        o_i_or_d     = 1'b0;
        o_mem_read   = 1'b0;
        o_mem_write  = 1'b0;
        o_ir_write   = 1'b0;
        o_reg_dst    = 1'b0;
        o_mem_to_reg = 1'b0;
        o_reg_write  = 1'b0;
        o_alu_src_a  = 1'b0;
        o_alu_src_b  = SRCB_RT;
        o_alu_op     = ALUOP_W'(ALU_ADD);
        o_pc_source  = PCS_ALU;
        o_trap       = 1'b0;
        case (r_state)
            S_FETCH: begin
                o_mem_read  = 1'b1;
                o_alu_src_b = SRCB_FOUR;
                o_ir_write  = i_mem_ready;
                o_pc_write  = i_mem_ready;
            end
            S_DECODE:  o_alu_src_b = SRCB_IMM_SH;
            S_MEMADDR, S_IEX: begin
                o_alu_src_a = 1'b1;
                o_alu_src_b = SRCB_IMM;
            end
            S_MEMRD: begin
                o_mem_read = 1'b1;
                o_i_or_d   = 1'b1;
            end
            S_MEMWB: begin
                o_reg_write  = 1'b1;
                o_mem_to_reg = 1'b1;
            end
            S_MEMWR: begin
                o_mem_write = 1'b1;
                o_i_or_d    = 1'b1;
            end
            S_REX: begin
                o_alu_src_a = 1'b1;
                o_alu_op    = ALUOP_W'(ALU_FUNCT);
            end
            S_REXWB: begin
                o_reg_write = 1'b1;
                o_reg_dst   = 1'b1;
            end
            S_IWB:     o_reg_write = 1'b1;
            S_BRANCH: begin
                o_alu_src_a = 1'b1;
                o_alu_op    = ALUOP_W'(ALU_SUB);
                o_pc_source = PCS_ALUOUT;
                o_beq       = ~r_sel;
                o_bne       = r_sel;
            end
            S_JUMP: begin
                o_pc_write  = 1'b1;
                o_pc_source = PCS_JUMP;
            end
            S_TRAP:    o_trap = 1'b1;
            default:   o_trap = 1'b0;
        endcase
    end
endmodule

// File: tb/tb_multicycle_control_unit.sv
// tb_multicycle_control_unit: directed per-cycle checks of the control-unit output vector
module tb_multicycle_control_unit;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [5:0] op_code = 6'd0;
    logic       mem_ready = 1'b0;
    logic       pc_write, beq, bne, i_or_d, mem_read, mem_write, ir_write;
    logic       reg_dst, mem_to_reg, reg_write, alu_src_a, trap;
    logic [1:0] alu_src_b, alu_op, pc_source;
    logic [17:0] obs;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    multicycle_control_unit #(.OPCODE_W(6), .ALUOP_W(2), .MEM_TIMEOUT(15)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_op_code(op_code), .i_mem_ready(mem_ready),
        .o_pc_write(pc_write), .o_beq(beq), .o_bne(bne), .o_i_or_d(i_or_d),
        .o_mem_read(mem_read), .o_mem_write(mem_write), .o_ir_write(ir_write),
        .o_reg_dst(reg_dst), .o_mem_to_reg(mem_to_reg), .o_reg_write(reg_write),
        .o_alu_src_a(alu_src_a), .o_alu_src_b(alu_src_b), .o_alu_op(alu_op),
        .o_pc_source(pc_source), .o_trap(trap)
    );

    // {pc_write beq bne}_{i_or_d mem_read mem_write}_{ir_write reg_dst mem_to_reg reg_write}_a_b_op_pcsrc_trap
    assign obs = {pc_write, beq, bne, i_or_d, mem_read, mem_write, ir_write, reg_dst,
                  mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op, pc_source, trap};

    localparam logic [17:0] V_ZERO    = 18'b000_000_0000_0_00_00_00_0;
    localparam logic [17:0] V_FETCH_W = 18'b000_010_0000_0_01_00_00_0;
    localparam logic [17:0] V_FETCH_R = 18'b100_010_1000_0_01_00_00_0;
    localparam logic [17:0] V_DECODE  = 18'b000_000_0000_0_11_00_00_0;
    localparam logic [17:0] V_MEMADDR = 18'b000_000_0000_1_10_00_00_0;
    localparam logic [17:0] V_MEMRD   = 18'b000_110_0000_0_00_00_00_0;
    localparam logic [17:0] V_MEMWB   = 18'b000_000_0011_0_00_00_00_0;
    localparam logic [17:0] V_MEMWR   = 18'b000_101_0000_0_00_00_00_0;
    localparam logic [17:0] V_REX     = 18'b000_000_0000_1_00_10_00_0;
    localparam logic [17:0] V_REXWB   = 18'b000_000_0101_0_00_00_00_0;
    localparam logic [17:0] V_IEX     = 18'b000_000_0000_1_10_00_00_0;
    localparam logic [17:0] V_IWB     = 18'b000_000_0001_0_00_00_00_0;
    localparam logic [17:0] V_BEQ     = 18'b010_000_0000_1_00_01_01_0;
    localparam logic [17:0] V_BNE     = 18'b001_000_0000_1_00_01_01_0;
    localparam logic [17:0] V_JUMP    = 18'b100_000_0000_0_00_00_10_0;
    localparam logic [17:0] V_TRAP    = 18'b000_000_0000_0_00_00_00_1;

    task automatic chk(input logic [17:0] exp, input string tag);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic cyc(input logic rdy, input logic [5:0] op, input logic [17:0] exp, input string tag);
        @(negedge clk);
        mem_ready = rdy;
        op_code = op;
        #1;
        chk(exp, tag);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk(V_ZERO, "reset_outputs");
        rst_n = 1'b1;
        #1;
        chk(V_ZERO, "idle_after_release");
    endtask

    initial begin
        do_reset();
        // ADDI, zero wait
        cyc(1, 6'b001000, V_FETCH_R, "addi_fetch");
        cyc(1, 6'b001000, V_DECODE,  "addi_decode");
        cyc(1, 6'b001000, V_IEX,     "addi_iex");
        cyc(1, 6'b001000, V_IWB,     "addi_iwb");
        // LW with a fetch wait, op_code flipped to SW after decode, 3 waits in MEMRD
        cyc(0, 6'b100011, V_FETCH_W, "lw_fetch_wait");
        cyc(1, 6'b100011, V_FETCH_R, "lw_fetch");
        cyc(1, 6'b100011, V_DECODE,  "lw_decode");
        cyc(1, 6'b101011, V_MEMADDR, "lw_memaddr");
        for (int i = 0; i < 3; i++) cyc(0, 6'b101011, V_MEMRD, "lw_memrd_wait");
        cyc(1, 6'b101011, V_MEMRD,   "lw_memrd_ready");
        cyc(1, 6'b101011, V_MEMWB,   "lw_memwb");
        // BNE then J back to back
        cyc(1, 6'b000101, V_FETCH_R, "bne_fetch");
        cyc(1, 6'b000101, V_DECODE,  "bne_decode");
        cyc(1, 6'b000010, V_BNE,     "bne_branch");
        cyc(1, 6'b000010, V_FETCH_R, "j_fetch");
        cyc(1, 6'b000010, V_DECODE,  "j_decode");
        cyc(1, 6'b000100, V_JUMP,    "j_jump");
        // BEQ
        cyc(1, 6'b000100, V_FETCH_R, "beq_fetch");
        cyc(1, 6'b000100, V_DECODE,  "beq_decode");
        cyc(1, 6'b000000, V_BEQ,     "beq_branch");
        // R-type
        cyc(1, 6'b000000, V_FETCH_R, "r_fetch");
        cyc(1, 6'b000000, V_DECODE,  "r_decode");
        cyc(1, 6'b000000, V_REX,     "r_rex");
        cyc(1, 6'b000000, V_REXWB,   "r_rexwb");
        // SW ready on the 15th wait-capable cycle: no trap
        cyc(1, 6'b101011, V_FETCH_R, "sw_fetch");
        cyc(1, 6'b101011, V_DECODE,  "sw_decode");
        cyc(1, 6'b101011, V_MEMADDR, "sw_memaddr");
        for (int i = 0; i < 14; i++) cyc(0, 6'b101011, V_MEMWR, "sw_memwr_wait");
        cyc(1, 6'b101011, V_MEMWR,   "sw_memwr_ready_at_limit");
        cyc(1, 6'b101011, V_FETCH_R, "sw_no_trap_fetch");
        // SW with memory never answering: mem_write for exactly 15 cycles, then trap
        cyc(1, 6'b101011, V_DECODE,  "swto_decode");
        cyc(1, 6'b101011, V_MEMADDR, "swto_memaddr");
        for (int i = 0; i < 15; i++) cyc(0, 6'b101011, V_MEMWR, "swto_memwr_wait");
        cyc(0, 6'b101011, V_TRAP,    "swto_trap");
        cyc(1, 6'b101011, V_TRAP,    "swto_trap_sticky");
        do_reset();
        // Illegal opcode traps and stays trapped
        cyc(1, 6'b111111, V_FETCH_R, "ill_fetch");
        cyc(1, 6'b111111, V_DECODE,  "ill_decode");
        for (int i = 0; i < 20; i++) cyc(i % 2 == 0, 6'b001000, V_TRAP, "ill_trap_hold");
        do_reset();
        cyc(1, 6'b001000, V_FETCH_R, "post_trap_fetch");
        // Asynchronous reset mid MEMWR
        cyc(1, 6'b101011, V_DECODE,  "ar_decode");
        cyc(1, 6'b101011, V_MEMADDR, "ar_memaddr");
        cyc(0, 6'b101011, V_MEMWR,   "ar_memwr");
        #2;
        rst_n = 1'b0;
        #1;
        chk(V_ZERO, "ar_async_drop");
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk(V_ZERO, "ar_idle");
        cyc(1, 6'b101011, V_FETCH_R, "ar_fetch");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
